// File: rtl/calc_engine_if.sv
// ============================================================================
//  Module      : calc_engine_if
//  Description : Keypad-to-calculator link. The keypad side (master) issues a
//                one-cycle newkey strobe with a 5-bit keycode; the calculator
//                side (slave) returns the display value, overflow flag and
//                multiply-busy indication.
//  Signals     : newkey  - key strobe, keycode valid while high
//                keycode - 5-bit key code
//                display - 16-bit value for the 4-digit hex display
//                ovf     - overflow of the most recent completed operation
//                busy    - high while a multiply is running
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface calc_engine_if;
  logic        newkey;
  logic [4:0]  keycode;
  logic [15:0] display;
  logic        ovf;
  logic        busy;

  modport master (output newkey, keycode, input display, ovf, busy);
  modport slave  (input newkey, keycode, output display, ovf, busy);
endinterface

`default_nettype wire

// File: rtl/calc_engine.sv
// ============================================================================
//  Module      : calc_engine
//  Description : 16-bit unsigned hex calculator. Accepts digit / editing /
//                operator keys, chains operators left to right, adds and
//                subtracts in one cycle and multiplies with a 16-cycle
//                shift-add sequence.
//  Ports       : clk - system clock
//                rst - asynchronous active-high reset
//                bus - calc_engine_if.slave (newkey, keycode in;
//                      display, ovf, busy out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_engine (
  input  wire logic     clk,
  input  wire logic     rst,
  calc_engine_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  // Operator encodings line up with the low two bits of the operator keycodes.
  localparam logic [1:0] c_OP_NONE = 2'd0;
  localparam logic [1:0] c_OP_ADD  = 2'd1;
  localparam logic [1:0] c_OP_SUB  = 2'd2;
  localparam logic [1:0] c_OP_MUL  = 2'd3;

  localparam logic [4:0] c_K_ADD       = 5'b00001;
  localparam logic [4:0] c_K_SUB       = 5'b00010;
  localparam logic [4:0] c_K_MUL       = 5'b00011;
  localparam logic [4:0] c_K_EQ        = 5'b00100;
  localparam logic [4:0] c_K_CLR_ALL   = 5'b01001;
  localparam logic [4:0] c_K_CLR_ENTRY = 5'b01010;
  localparam logic [4:0] c_K_BKSP      = 5'b01011;
  localparam logic [4:0] c_K_NEG       = 5'b01100;

  state_t      r_state,   w_state;
  logic [15:0] r_acc,     w_acc;
  logic [15:0] r_entry,   w_entry;
  logic [1:0]  r_pend_op, w_pend_op;
  logic [1:0]  r_next_op, w_next_op;
  logic        r_fresh,   w_fresh;
  logic [2:0]  r_cnt,     w_cnt;
  logic        r_ovf,     w_ovf;
  logic [31:0] r_prod,    w_prod;
  logic [31:0] r_mcand,   w_mcand;
  logic [15:0] r_mplier,  w_mplier;
  logic [3:0]  r_iter,    w_iter;

  logic [16:0] w_sum;
  logic [16:0] w_diff;
  logic [15:0] w_alu_r;
  logic        w_alu_ovf;
  logic [31:0] w_prod_step;
  logic [1:0]  w_new_op;

  // Single-cycle add/sub; the 17th bit is carry for add, borrow for sub.
  assign w_sum     = {1'b0, r_acc} + {1'b0, r_entry};
  assign w_diff    = {1'b0, r_acc} - {1'b0, r_entry};
  assign w_alu_r   = (r_pend_op == c_OP_SUB) ? w_diff[15:0] : w_sum[15:0];
  assign w_alu_ovf = (r_pend_op == c_OP_SUB) ? w_diff[16]   : w_sum[16];

  // One shift-add iteration: accumulate the shifted multiplicand when the
  // current multiplier LSB is set.
  assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : 32'd0);

  // Equals carries no follow-on operator.
  assign w_new_op = (bus.keycode == c_K_EQ) ? c_OP_NONE : bus.keycode[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= 16'h0000;
      r_entry   <= 16'h0000;
      r_pend_op <= c_OP_NONE;
      r_next_op <= c_OP_NONE;
      r_fresh   <= 1'b0;
      r_cnt     <= 3'd0;
      r_ovf     <= 1'b0;
      r_prod    <= 32'd0;
      r_mcand   <= 32'd0;
      r_mplier  <= 16'h0000;
      r_iter    <= 4'd0;
    end else begin
      r_state   <= w_state;
      r_acc     <= w_acc;
      r_entry   <= w_entry;
      r_pend_op <= w_pend_op;
      r_next_op <= w_next_op;
      r_fresh   <= w_fresh;
      r_cnt     <= w_cnt;
      r_ovf     <= w_ovf;
      r_prod    <= w_prod;
      r_mcand   <= w_mcand;
      r_mplier  <= w_mplier;
      r_iter    <= w_iter;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_acc     = r_acc;
    w_entry   = r_entry;
    w_pend_op = r_pend_op;
    w_next_op = r_next_op;
    w_fresh   = r_fresh;
    w_cnt     = r_cnt;
    w_ovf     = r_ovf;
    w_prod    = r_prod;
    w_mcand   = r_mcand;
    w_mplier  = r_mplier;
    w_iter    = r_iter;

    if (bus.newkey && (bus.keycode == c_K_CLR_ALL)) begin
      // Clear all wins in every state and abandons any multiply in flight.
      w_state   = S_IDLE;
      w_acc     = 16'h0000;
      w_entry   = 16'h0000;
      w_pend_op = c_OP_NONE;
      w_next_op = c_OP_NONE;
      w_fresh   = 1'b0;
      w_cnt     = 3'd0;
      w_ovf     = 1'b0;
      w_prod    = 32'd0;
      w_mcand   = 32'd0;
      w_mplier  = 16'h0000;
      w_iter    = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.newkey) begin
            if (bus.keycode[4]) begin
              if (r_fresh) begin
                w_entry = {12'h000, bus.keycode[3:0]};
                w_cnt   = 3'd1;
                w_fresh = 1'b0;
              end else if (r_cnt < 3'd4) begin
                w_entry = {r_entry[11:0], bus.keycode[3:0]};
                w_cnt   = r_cnt + 3'd1;
              end
            end else begin
              case (bus.keycode)
                c_K_CLR_ENTRY: begin
                  w_entry = 16'h0000;
                  w_cnt   = 3'd0;
                  w_fresh = 1'b0;
                end
                c_K_BKSP: begin
                  if (!r_fresh) begin
                    w_entry = r_entry >> 4;
                    if (r_cnt != 3'd0) w_cnt = r_cnt - 3'd1;
                  end
                end
                c_K_NEG: w_entry = ~r_entry + 16'd1;
                c_K_ADD, c_K_SUB, c_K_MUL, c_K_EQ: begin
                  if ((bus.keycode != c_K_EQ) && r_fresh && (r_pend_op != c_OP_NONE)) begin
                    // Operator typed twice in a row: just swap the operator.
                    w_pend_op = w_new_op;
                  end else if (r_pend_op == c_OP_NONE) begin
                    w_fresh = 1'b1;
                    if (bus.keycode != c_K_EQ) begin
                      w_acc     = r_entry;
                      w_pend_op = w_new_op;
                    end
                  end else if (r_pend_op == c_OP_MUL) begin
                    w_state   = S_MUL;
                    w_next_op = w_new_op;
                    w_prod    = 32'd0;
                    w_mcand   = {16'h0000, r_acc};
                    w_mplier  = r_entry;
                    w_iter    = 4'd0;
                  end else begin
                    w_acc     = w_alu_r;
                    w_entry   = w_alu_r;
                    w_pend_op = w_new_op;
                    w_fresh   = 1'b1;
                    w_ovf     = w_alu_ovf;
                  end
                end
                default: ;
              endcase
            end
          end
        end

        S_MUL: begin
          // Other keys are dropped while multiplying.
          w_prod   = w_prod_step;
          w_mcand  = r_mcand << 1;
          w_mplier = r_mplier >> 1;
          w_iter   = r_iter + 4'd1;
          if (r_iter == 4'd15) begin
            w_state   = S_IDLE;
            w_acc     = w_prod_step[15:0];
            w_entry   = w_prod_step[15:0];
            w_ovf     = |w_prod_step[31:16];
            w_pend_op = r_next_op;
            w_fresh   = 1'b1;
          end
        end

        default: w_state = S_IDLE;
      endcase
    end
  end

  assign bus.display = r_entry;
  assign bus.ovf     = r_ovf;
  assign bus.busy    = (r_state == S_MUL);

endmodule

`default_nettype wire

// File: tb/tb_calc_engine.sv
// ============================================================================
//  Module      : tb_calc_engine
//  Description : Self-checking bench for calc_engine: directed key sequences
//                with literal expectations plus a randomized key stream
//                compared every cycle against a behavioural calculator model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_engine;

  localparam logic [4:0] c_K_ADD = 5'b00001;
  localparam logic [4:0] c_K_SUB = 5'b00010;
  localparam logic [4:0] c_K_MUL = 5'b00011;
  localparam logic [4:0] c_K_EQ  = 5'b00100;
  localparam logic [4:0] c_K_CA  = 5'b01001;
  localparam logic [4:0] c_K_CE  = 5'b01010;
  localparam logic [4:0] c_K_BS  = 5'b01011;
  localparam logic [4:0] c_K_NEG = 5'b01100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  calc_engine_if bus();

  calc_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state. Operators: 0 none, 1 add, 2 sub, 3 mul.
  int     m_acc, m_entry, m_pend, m_next, m_cnt, m_left;
  bit     m_fresh, m_ovf, m_busy;
  longint m_prod;

  task automatic m_reset();
    m_acc = 0; m_entry = 0; m_pend = 0; m_next = 0; m_cnt = 0; m_left = 0;
    m_fresh = 0; m_ovf = 0; m_busy = 0; m_prod = 0;
  endtask

  task automatic m_finish(input longint r, input bit o, input int nop);
    m_acc = int'(r % 65536); m_entry = m_acc; m_ovf = o;
    m_pend = nop; m_fresh = 1;
  endtask

  task automatic m_key(input logic [4:0] k);
    int nop;
    nop = (k == c_K_EQ) ? 0 : int'(k);
    if (k[4]) begin
      if (m_fresh) begin m_entry = int'(k[3:0]); m_cnt = 1; m_fresh = 0; end
      else if (m_cnt < 4) begin m_entry = (m_entry * 16 + int'(k[3:0])) % 65536; m_cnt++; end
    end else if (k == c_K_CA) m_reset();
    else if (k == c_K_CE) begin m_entry = 0; m_cnt = 0; m_fresh = 0; end
    else if (k == c_K_BS) begin
      if (!m_fresh) begin m_entry = m_entry / 16; if (m_cnt > 0) m_cnt--; end
    end else if (k == c_K_NEG) m_entry = (65536 - m_entry) % 65536;
    else if (k >= c_K_ADD && k <= c_K_EQ) begin
      if (k != c_K_EQ && m_fresh && m_pend != 0) m_pend = nop;
      else if (m_pend == 0) begin
        m_fresh = 1;
        if (k != c_K_EQ) begin m_acc = m_entry; m_pend = nop; end
      end else if (m_pend == 3) begin
        m_prod = longint'(m_acc) * longint'(m_entry);
        m_next = nop; m_busy = 1; m_left = 16;
      end else if (m_pend == 1) m_finish(longint'(m_acc + m_entry), (m_acc + m_entry) > 65535, nop);
      else m_finish(longint'(m_acc - m_entry + 65536), m_acc < m_entry, nop);
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else if (m_busy) begin
        if (bus.newkey && bus.keycode == c_K_CA) m_reset();
        else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 0;
            m_finish(m_prod, m_prod > 65535, m_next);
          end
        end
      end else if (bus.newkey) m_key(bus.keycode);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    chk("display", 32'(bus.display), 32'(m_entry));
    chk("ovf",     32'(bus.ovf),     32'(m_ovf));
    chk("busy",    32'(bus.busy),    32'(m_busy));
  end

  // Inputs change only at falling edges; each key occupies one cycle.
  task automatic key(input logic [4:0] k);
    bus.newkey = 1'b1; bus.keycode = k;
    @(negedge clk);
    bus.newkey = 1'b0;
  endtask

  function automatic logic [4:0] dg(input int d);
    return {1'b1, 4'(d)};
  endfunction

  // Counts busy cycles (bounded); optionally injects a digit on busy cycle 3.
  task automatic wait_idle(input bit inject, output int n);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      bus.newkey  = inject && (n == 3);
      bus.keycode = dg(9);
      @(negedge clk);
    end
    bus.newkey = 1'b0;
  endtask

  task automatic lit(input string name, input logic [15:0] d, input logic o);
    chk({name, "_disp"}, 32'(bus.display), 32'(d));
    chk({name, "_ovf"},  32'(bus.ovf),     32'(o));
  endtask

  initial begin
    int n;
    int r;
    bus.newkey = 1'b0; bus.keycode = 5'd0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    lit("reset", 16'h0000, 1'b0);
    chk("reset_busy", 32'(bus.busy), 32'd0);

    key(dg(1)); key(dg(2)); key(dg(3)); key(dg(4)); key(dg(5));
    lit("entry_limit", 16'h1234, 1'b0);
    key(c_K_BS);   lit("backspace", 16'h0123, 1'b0);
    key(c_K_CE);   lit("clear_entry", 16'h0000, 1'b0);
    key(dg(7));    lit("digit_after_ce", 16'h0007, 1'b0);

    key(c_K_CA); key(dg(1)); key(dg(2)); key(c_K_ADD); key(dg(3)); key(dg(4)); key(c_K_EQ);
    lit("add", 16'h0046, 1'b0);
    key(c_K_CA); repeat (4) key(dg(15)); key(c_K_ADD); key(dg(2)); key(c_K_EQ);
    lit("add_carry", 16'h0001, 1'b1);
    key(c_K_CA); key(dg(3)); key(c_K_SUB); key(dg(5)); key(c_K_EQ);
    lit("sub_borrow", 16'hFFFE, 1'b1);

    key(c_K_CA); key(dg(1)); key(dg(2)); key(c_K_MUL); key(dg(3)); key(c_K_EQ);
    wait_idle(1'b1, n);
    chk("mul_busy_cycles", 32'(n), 32'd16);
    lit("mul", 16'h0036, 1'b0);
    key(c_K_CA); key(dg(1)); key(dg(0)); key(dg(0)); key(c_K_MUL);
    key(dg(1)); key(dg(0)); key(dg(0)); key(c_K_EQ);
    wait_idle(1'b0, n);
    lit("mul_ovf", 16'h0000, 1'b1);

    key(c_K_CA); key(dg(2)); key(c_K_ADD); key(dg(3)); key(c_K_MUL);
    lit("chain_mid", 16'h0005, 1'b0);
    key(dg(4)); key(c_K_EQ); wait_idle(1'b0, n);
    lit("chain_end", 16'h0014, 1'b0);
    key(c_K_CA); key(dg(9)); key(c_K_ADD); key(c_K_SUB); key(dg(1)); key(c_K_EQ);
    lit("op_replace", 16'h0008, 1'b0);
    key(c_K_CA); key(dg(5)); key(c_K_ADD); key(c_K_EQ);
    lit("eq_fresh", 16'h000A, 1'b0);
    key(c_K_CA); key(dg(1)); key(c_K_NEG);
    lit("negate", 16'hFFFF, 1'b0);

    key(c_K_CA); key(dg(1)); key(dg(2)); key(c_K_MUL); key(dg(3)); key(dg(4)); key(c_K_EQ);
    repeat (4) @(negedge clk);
    key(c_K_CA);
    lit("abort", 16'h0000, 1'b0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    key(dg(3));   lit("after_abort", 16'h0003, 1'b0);

    key(c_K_CA); repeat (4) key(dg(15)); key(c_K_MUL); key(dg(2)); key(c_K_EQ);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    lit("async_rst", 16'h0000, 1'b0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      bus.newkey = ($urandom_range(0, 1) == 1);
      if (r < 45)      bus.keycode = dg($urandom_range(0, 15));
      else if (r < 60) bus.keycode = 5'($urandom_range(1, 3));
      else if (r < 68) bus.keycode = c_K_EQ;
      else if (r < 73) bus.keycode = c_K_CE;
      else if (r < 80) bus.keycode = c_K_BS;
      else if (r < 85) bus.keycode = c_K_NEG;
      else if (r < 87) bus.keycode = c_K_CA;
      else             bus.keycode = 5'($urandom_range(0, 31));
      @(negedge clk);
    end
    bus.newkey = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/calc_engine.md
# calc_engine

Calculator datapath and control that consumes the keypad interface's `newkey`/`keycode` stream and produces the 16-bit value shown on the 4-digit hex display. It sits directly downstream of the keypad block. It performs:
- 4-digit hex entry, with backspace, clear entry and clear all;
- unsigned add, subtract and multiply, with left-to-right operator chaining;
- an overflow flag.

Multiply is a sequential shift-add over 16 cycles. Add and subtract complete in one cycle.

## Interface
- No parameters. Data width is fixed at 16 bits (4 hex digits).
- `clk` in 1: system clock, 5 MHz, shared with the keypad block.
- `rst` in 1: asynchronous, active-high reset.
- `newkey` in 1: one-cycle strobe from the keypad; `keycode` is valid while it is high.
- `keycode` in 5: key code.
  - `1dddd` = hex digit `dddd`.
  - `00001` = +, `00010` = −, `00011` = ×, `00100` = =.
  - `01001` = clear all, `01010` = clear entry, `01011` = backspace, `01100` = negate.
  - All other codes are ignored.
- `display` out 16: value to show; always equals the internal entry register.
- `ovf` out 1: overflow from the most recent completed operation.
- `busy` out 1: high while a multiply is in progress.

## Operation
- Internal registers:
  - `acc[15:0]`;
  - `entry[15:0]`, which drives `display`;
  - `pend_op` (NONE / ADD / SUB / MUL);
  - `next_op`;
  - `fresh` flag (the next digit starts a new number);
  - `cnt[2:0]` (digits entered, 0..4);
  - multiplier state: 32-bit product, shift registers, 4-bit iteration counter.
- FSM states: IDLE and MUL. In IDLE, a key is acted on in the cycle `newkey` is high.
- Digit key:
  - If `fresh`: `entry` = `{12'h000, d}`, `cnt` = 1, `fresh` = 0.
  - Else if `cnt` < 4: `entry` = `{entry[11:0], d}`, `cnt` += 1.
  - Else (`cnt` = 4): the digit is ignored.
- Backspace:
  - If `fresh`: ignored.
  - Else: `entry` = `entry >> 4`, and `cnt` is decremented if nonzero.
- Clear entry: `entry` = 0, `cnt` = 0, `fresh` = 0. `acc`, `pend_op` and `ovf` are unchanged.
- Negate: `entry` = `(~entry + 1)` mod 2^16. `cnt`, `fresh` and `ovf` are unchanged.
- Clear all: every register returns to its reset value. This key is accepted in any state, including MUL, where it aborts the multiply.
- Operator key (+, −, ×):
  - If `fresh` and `pend_op` ≠ NONE: only `pend_op` is replaced (no computation).
  - Else if `pend_op` = NONE: `acc` = `entry`, `pend_op` = new op, `fresh` = 1.
  - Else: compute R = `acc` `pend_op` `entry`, then `acc` = R, `entry` = R, `pend_op` = new op, `fresh` = 1, `ovf` = result overflow.
- Equals key:
  - If `pend_op` = NONE: `fresh` = 1 and nothing else changes.
  - Else: compute R = `acc` `pend_op` `entry`, even when `fresh` (so "5 + =" gives 000A). Then `acc` = R, `entry` = R, `pend_op` = NONE, `fresh` = 1, `ovf` = result overflow.
- Arithmetic (all unsigned, 16-bit):
  - ADD: R = low 16 bits of the sum; ovf = carry out.
  - SUB: R = `acc − entry` mod 2^16; ovf = borrow (`acc < entry`).
  - MUL: R = low 16 bits of the 32-bit product; ovf = (upper 16 bits ≠ 0).
- Multiply path:
  - When a computation needs MUL, the FSM enters MUL.
  - The op that follows (the new operator, or NONE for =) is held in `next_op`.
  - The multiplier runs 16 shift-add iterations, one per cycle.
  - On completion it writes R and `ovf`, sets `pend_op` = `next_op`, sets `fresh` = 1, and returns to IDLE.
- Keys arriving in MUL, other than clear all, are dropped with no effect.

## Timing
- Reset values: `display` = 0000, `ovf` = 0, `busy` = 0, `acc` = 0, `pend_op` = NONE, `fresh` = 0, `cnt` = 0, FSM = IDLE.
- Non-multiply keys: with `newkey` sampled at edge N, every register update (including `display` and `ovf`) is visible after edge N.
- Multiply:
  - With the key sampled at edge N, `busy` = 1 after edge N.
  - `busy` stays high for exactly 16 cycles.
  - `display`, `ovf` and `pend_op` update on the same edge at which `busy` falls (edge N+16).
  - A new key is accepted in the cycle after `busy` falls.
- Clear all during MUL: at the next edge, `busy` = 0, `display` = 0 and `ovf` = 0. The partial product is discarded.
- Asynchronous `rst` asserted mid-multiply: immediate return to the reset values.
- `newkey` together with an ignored code: no state change.

## Test plan
- Reset: assert `rst` mid-operation → `display` = 0000, `ovf` = 0, `busy` = 0 immediately.
- Entry limit and editing:
  - Digits 1,2,3,4,5 → `display` = 1234 (the 5 is ignored).
  - Backspace → 0123.
  - Clear entry → 0000.
  - Digit 7 → 0007.
- Add and subtract:
  - 0012 + 0034 = → 0046, ovf 0, one cycle after the = strobe.
  - FFFF + 0002 = → 0001, ovf 1.
  - 0003 − 0005 = → FFFE, ovf 1.
- Multiply and busy:
  - 0012 × 0003 = → `busy` high for exactly 16 cycles, then 0036, ovf 0.
  - A digit strobe while busy is ignored.
  - 0100 × 0100 = → 0000, ovf 1.
- Chaining and operator replacement:
  - 2 + 3 × 4 = → `display` 0005 after ×, 0014 after =.
  - 9 + − 1 = → 0008.
  - 5 + = → 000A.
  - Negate 0001 → FFFF.
- Abort: 0012 × 0034 =, then clear all at the 5th busy cycle → next cycle `busy` = 0, `display` = 0000. A subsequent digit 3 → 0003.
